// File: rtl/rs_alu_issue_pkg.sv
// Shared widths, entry payload and CDB tag-match helper for the ALU reservation station.
package rs_alu_issue_pkg;

  localparam int unsigned PR_W  = 7;
  localparam int unsigned AR_W  = 5;
  localparam int unsigned NPC_W = 64;
  localparam int unsigned IR_W  = 32;
  localparam int unsigned SEL_W = 2;

  typedef struct packed {
    logic [NPC_W-1:0] npc;
    logic [IR_W-1:0]  ir;
    logic [AR_W-1:0]  dest_ar;
    logic [PR_W-1:0]  dest_pr;
    logic [PR_W-1:0]  pra;
    logic [PR_W-1:0]  prb;
    logic [SEL_W-1:0] opa_sel;
    logic [SEL_W-1:0] opb_sel;
  } rs_entry_t;

  // True when either valid CDB port broadcasts the given tag.
  function automatic logic cdb_hit(input logic [PR_W-1:0] tag,
                                   input logic c0, input logic [PR_W-1:0] t0,
                                   input logic c1, input logic [PR_W-1:0] t1);
    return (c0 && (t0 == tag)) || (c1 && (t1 == tag));
  endfunction

endpackage

// File: rtl/rs_psel.sv
// Two-grant priority selector: one-hot lowest and second-lowest set request bits.
module rs_psel #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt0_c,
  output logic [N-1:0] gnt1_c
);

  logic [N-1:0] rest_c;

  // x & -x isolates the lowest set bit.
  assign gnt0_c = req & (~req + N'(1));
  assign rest_c = req & ~gnt0_c;
  assign gnt1_c = rest_c & (~rest_c + N'(1));

endmodule

// File: rtl/rs_alu_issue.sv
// ALU reservation station: dual dispatch, CDB wakeup, dual registered issue.
// Optional RS_FLUSH_EN adds a flush input that empties the station.
module rs_alu_issue
  import rs_alu_issue_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic              clock,
  input  logic              reset,
`ifdef RS_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              id_valid_inst0,
  input  logic              id_valid_inst1,
  input  logic [NPC_W-1:0]  id_NPC0,
  input  logic [NPC_W-1:0]  id_NPC1,
  input  logic [IR_W-1:0]   id_IR0,
  input  logic [IR_W-1:0]   id_IR1,
  input  logic [AR_W-1:0]   id_dest_ar_idx0,
  input  logic [AR_W-1:0]   id_dest_ar_idx1,
  input  logic [PR_W-1:0]   id_dest_pr_idx0,
  input  logic [PR_W-1:0]   id_dest_pr_idx1,
  input  logic [PR_W-1:0]   id_pra_idx0,
  input  logic [PR_W-1:0]   id_pra_idx1,
  input  logic [PR_W-1:0]   id_prb_idx0,
  input  logic [PR_W-1:0]   id_prb_idx1,
  input  logic              id_pra_ready0,
  input  logic              id_pra_ready1,
  input  logic              id_prb_ready0,
  input  logic              id_prb_ready1,
  input  logic [SEL_W-1:0]  id_opa_select0,
  input  logic [SEL_W-1:0]  id_opa_select1,
  input  logic [SEL_W-1:0]  id_opb_select0,
  input  logic [SEL_W-1:0]  id_opb_select1,
  input  logic              cdb_complete0,
  input  logic              cdb_complete1,
  input  logic [PR_W-1:0]   cdb_prf_dest_pr_idx0,
  input  logic [PR_W-1:0]   cdb_prf_dest_pr_idx1,
  input  logic [1:0]        rs_alu_avail,
  output logic [1:0]        rs_avail_cnt,
  output logic              rs_valid_inst0,
  output logic              rs_valid_inst1,
  output logic [NPC_W-1:0]  rs_NPC0,
  output logic [NPC_W-1:0]  rs_NPC1,
  output logic [IR_W-1:0]   rs_IR0,
  output logic [IR_W-1:0]   rs_IR1,
  output logic [AR_W-1:0]   rs_dest_ar_idx0,
  output logic [AR_W-1:0]   rs_dest_ar_idx1,
  output logic [PR_W-1:0]   rs_dest_pr_idx0,
  output logic [PR_W-1:0]   rs_dest_pr_idx1,
  output logic [SEL_W-1:0]  rs_opa_select0,
  output logic [SEL_W-1:0]  rs_opa_select1,
  output logic [SEL_W-1:0]  rs_opb_select0,
  output logic [SEL_W-1:0]  rs_opb_select1,
  output logic [PR_W-1:0]   rs_pra_idx0,
  output logic [PR_W-1:0]   rs_pra_idx1,
  output logic [PR_W-1:0]   rs_prb_idx0,
  output logic [PR_W-1:0]   rs_prb_idx1
);

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] pra_rdy_q, pra_rdy_d;
  logic [RS_SIZE-1:0] prb_rdy_q, prb_rdy_d;
  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];

  logic               rs_valid0_q, rs_valid0_d;
  logic               rs_valid1_q, rs_valid1_d;
  rs_entry_t          out0_q, out0_d;
  rs_entry_t          out1_q, out1_d;

  logic [RS_SIZE-1:0] free_c, ready_c;
  logic [RS_SIZE-1:0] alloc0_c, alloc1_c, first_c, second_c;
  logic [RS_SIZE-1:0] iss0_c, iss1_c, wr0_c, wr1_c;
  rs_entry_t          id0_c, id1_c;

  assign free_c  = ~valid_q;
  assign ready_c = valid_q & pra_rdy_q & prb_rdy_q;

  rs_psel #(.N(RS_SIZE)) u_free_sel (
    .req    (free_c),
    .gnt0_c (alloc0_c),
    .gnt1_c (alloc1_c)
  );

  rs_psel #(.N(RS_SIZE)) u_ready_sel (
    .req    (ready_c),
    .gnt0_c (first_c),
    .gnt1_c (second_c)
  );

  // Credits come only from registered occupancy, capped at two.
  assign rs_avail_cnt = (|alloc1_c) ? 2'd2 : ((|alloc0_c) ? 2'd1 : 2'd0);

  assign id0_c = '{npc: id_NPC0, ir: id_IR0, dest_ar: id_dest_ar_idx0, dest_pr: id_dest_pr_idx0,
                   pra: id_pra_idx0, prb: id_prb_idx0, opa_sel: id_opa_select0,
                   opb_sel: id_opb_select0};
  assign id1_c = '{npc: id_NPC1, ir: id_IR1, dest_ar: id_dest_ar_idx1, dest_pr: id_dest_pr_idx1,
                   pra: id_pra_idx1, prb: id_prb_idx1, opa_sel: id_opa_select1,
                   opb_sel: id_opb_select1};

  // Map first/second ready candidates onto the available issue slots.
  always_comb begin
    iss0_c = '0;
    iss1_c = '0;
    case (rs_alu_avail)
      2'b11: begin
        iss0_c = first_c;
        iss1_c = second_c;
      end
      2'b01:   iss0_c = first_c;
      2'b10:   iss1_c = first_c;
      default: ;
    endcase
  end

  // Slot 1 takes the lowest free entry when slot 0 is idle, so one credit is never wasted.
  assign wr0_c = id_valid_inst0 ? alloc0_c : '0;
  assign wr1_c = !id_valid_inst1 ? '0 : (id_valid_inst0 ? alloc1_c : alloc0_c);

  always_comb begin
    valid_d     = valid_q;
    pra_rdy_d   = pra_rdy_q;
    prb_rdy_d   = prb_rdy_q;
    ent_d       = ent_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    rs_valid0_d = |iss0_c;
    rs_valid1_d = |iss1_c;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cdb_hit(ent_q[i].pra, cdb_complete0, cdb_prf_dest_pr_idx0,
                  cdb_complete1, cdb_prf_dest_pr_idx1)) pra_rdy_d[i] = 1'b1;
      if (cdb_hit(ent_q[i].prb, cdb_complete0, cdb_prf_dest_pr_idx0,
                  cdb_complete1, cdb_prf_dest_pr_idx1)) prb_rdy_d[i] = 1'b1;
      if (iss0_c[i] || iss1_c[i]) valid_d[i] = 1'b0;
      if (iss0_c[i]) out0_d = ent_q[i];
      if (iss1_c[i]) out1_d = ent_q[i];
      if (wr0_c[i]) begin
        valid_d[i]   = 1'b1;
        ent_d[i]     = id0_c;
        pra_rdy_d[i] = id_pra_ready0 || cdb_hit(id_pra_idx0, cdb_complete0, cdb_prf_dest_pr_idx0,
                                                cdb_complete1, cdb_prf_dest_pr_idx1);
        prb_rdy_d[i] = id_prb_ready0 || cdb_hit(id_prb_idx0, cdb_complete0, cdb_prf_dest_pr_idx0,
                                                cdb_complete1, cdb_prf_dest_pr_idx1);
      end
      if (wr1_c[i]) begin
        valid_d[i]   = 1'b1;
        ent_d[i]     = id1_c;
        pra_rdy_d[i] = id_pra_ready1 || cdb_hit(id_pra_idx1, cdb_complete0, cdb_prf_dest_pr_idx0,
                                                cdb_complete1, cdb_prf_dest_pr_idx1);
        prb_rdy_d[i] = id_prb_ready1 || cdb_hit(id_prb_idx1, cdb_complete0, cdb_prf_dest_pr_idx0,
                                                cdb_complete1, cdb_prf_dest_pr_idx1);
      end
    end
`ifdef RS_FLUSH_EN
    if (flush) begin
      valid_d     = '0;
      rs_valid0_d = 1'b0;
      rs_valid1_d = 1'b0;
      out0_d      = out0_q;
      out1_d      = out1_q;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      pra_rdy_q   <= '0;
      prb_rdy_q   <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      rs_valid0_q <= 1'b0;
      rs_valid1_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      pra_rdy_q   <= pra_rdy_d;
      prb_rdy_q   <= prb_rdy_d;
      ent_q       <= ent_d;
      rs_valid0_q <= rs_valid0_d;
      rs_valid1_q <= rs_valid1_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
    end
  end

  // Upstream must respect the advertised credits.
  a_dispatch_credit : assert property (@(posedge clock) disable iff (reset)
    ({1'b0, id_valid_inst0} + {1'b0, id_valid_inst1}) <= rs_avail_cnt);

  assign rs_valid_inst0  = rs_valid0_q;
  assign rs_valid_inst1  = rs_valid1_q;
  assign rs_NPC0         = out0_q.npc;
  assign rs_NPC1         = out1_q.npc;
  assign rs_IR0          = out0_q.ir;
  assign rs_IR1          = out1_q.ir;
  assign rs_dest_ar_idx0 = out0_q.dest_ar;
  assign rs_dest_ar_idx1 = out1_q.dest_ar;
  assign rs_dest_pr_idx0 = out0_q.dest_pr;
  assign rs_dest_pr_idx1 = out1_q.dest_pr;
  assign rs_opa_select0  = out0_q.opa_sel;
  assign rs_opa_select1  = out1_q.opa_sel;
  assign rs_opb_select0  = out0_q.opb_sel;
  assign rs_opb_select1  = out1_q.opb_sel;
  assign rs_pra_idx0     = out0_q.pra;
  assign rs_pra_idx1     = out1_q.pra;
  assign rs_prb_idx0     = out0_q.prb;
  assign rs_prb_idx1     = out1_q.prb;

endmodule

// File: tb/tb_rs_alu_issue.sv
// Directed bench for rs_alu_issue: vector table plus hand-written multi-cycle sequences.
module tb_rs_alu_issue;

  logic        clock = 1'b0;
  logic        reset;
`ifdef RS_FLUSH_EN
  logic        flush;
`endif
  logic        id_valid_inst0, id_valid_inst1;
  logic [63:0] id_NPC0, id_NPC1;
  logic [31:0] id_IR0, id_IR1;
  logic [4:0]  id_dest_ar_idx0, id_dest_ar_idx1;
  logic [6:0]  id_dest_pr_idx0, id_dest_pr_idx1;
  logic [6:0]  id_pra_idx0, id_pra_idx1, id_prb_idx0, id_prb_idx1;
  logic        id_pra_ready0, id_pra_ready1, id_prb_ready0, id_prb_ready1;
  logic [1:0]  id_opa_select0, id_opa_select1, id_opb_select0, id_opb_select1;
  logic        cdb_complete0, cdb_complete1;
  logic [6:0]  cdb_prf_dest_pr_idx0, cdb_prf_dest_pr_idx1;
  logic [1:0]  rs_alu_avail;
  logic [1:0]  rs_avail_cnt;
  logic        rs_valid_inst0, rs_valid_inst1;
  logic [63:0] rs_NPC0, rs_NPC1;
  logic [31:0] rs_IR0, rs_IR1;
  logic [4:0]  rs_dest_ar_idx0, rs_dest_ar_idx1;
  logic [6:0]  rs_dest_pr_idx0, rs_dest_pr_idx1;
  logic [1:0]  rs_opa_select0, rs_opa_select1, rs_opb_select0, rs_opb_select1;
  logic [6:0]  rs_pra_idx0, rs_pra_idx1, rs_prb_idx0, rs_prb_idx1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rs_alu_issue dut (
    .clock(clock), .reset(reset),
`ifdef RS_FLUSH_EN
    .flush(flush),
`endif
    .id_valid_inst0(id_valid_inst0), .id_valid_inst1(id_valid_inst1),
    .id_NPC0(id_NPC0), .id_NPC1(id_NPC1), .id_IR0(id_IR0), .id_IR1(id_IR1),
    .id_dest_ar_idx0(id_dest_ar_idx0), .id_dest_ar_idx1(id_dest_ar_idx1),
    .id_dest_pr_idx0(id_dest_pr_idx0), .id_dest_pr_idx1(id_dest_pr_idx1),
    .id_pra_idx0(id_pra_idx0), .id_pra_idx1(id_pra_idx1),
    .id_prb_idx0(id_prb_idx0), .id_prb_idx1(id_prb_idx1),
    .id_pra_ready0(id_pra_ready0), .id_pra_ready1(id_pra_ready1),
    .id_prb_ready0(id_prb_ready0), .id_prb_ready1(id_prb_ready1),
    .id_opa_select0(id_opa_select0), .id_opa_select1(id_opa_select1),
    .id_opb_select0(id_opb_select0), .id_opb_select1(id_opb_select1),
    .cdb_complete0(cdb_complete0), .cdb_complete1(cdb_complete1),
    .cdb_prf_dest_pr_idx0(cdb_prf_dest_pr_idx0), .cdb_prf_dest_pr_idx1(cdb_prf_dest_pr_idx1),
    .rs_alu_avail(rs_alu_avail), .rs_avail_cnt(rs_avail_cnt),
    .rs_valid_inst0(rs_valid_inst0), .rs_valid_inst1(rs_valid_inst1),
    .rs_NPC0(rs_NPC0), .rs_NPC1(rs_NPC1), .rs_IR0(rs_IR0), .rs_IR1(rs_IR1),
    .rs_dest_ar_idx0(rs_dest_ar_idx0), .rs_dest_ar_idx1(rs_dest_ar_idx1),
    .rs_dest_pr_idx0(rs_dest_pr_idx0), .rs_dest_pr_idx1(rs_dest_pr_idx1),
    .rs_opa_select0(rs_opa_select0), .rs_opa_select1(rs_opa_select1),
    .rs_opb_select0(rs_opb_select0), .rs_opb_select1(rs_opb_select1),
    .rs_pra_idx0(rs_pra_idx0), .rs_pra_idx1(rs_pra_idx1),
    .rs_prb_idx0(rs_prb_idx0), .rs_prb_idx1(rs_prb_idx1)
  );

  // One dispatch/issue scenario from an empty station; avail encoded 0..3.
  typedef struct {
    int v0; int v1;
    int pa0; int pb0; int ra0; int rb0;
    int pa1; int pb1; int ra1; int rb1;
    int c0; int t0; int c1; int t1;
    int avail;
    int ev0; int ev1; int ep0; int ep1;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid_inst0 = 1'b0; id_valid_inst1 = 1'b0;
    id_NPC0 = '0; id_NPC1 = '0; id_IR0 = '0; id_IR1 = '0;
    id_dest_ar_idx0 = '0; id_dest_ar_idx1 = '0; id_dest_pr_idx0 = '0; id_dest_pr_idx1 = '0;
    id_pra_idx0 = '0; id_pra_idx1 = '0; id_prb_idx0 = '0; id_prb_idx1 = '0;
    id_pra_ready0 = 1'b0; id_pra_ready1 = 1'b0; id_prb_ready0 = 1'b0; id_prb_ready1 = 1'b0;
    id_opa_select0 = '0; id_opa_select1 = '0; id_opb_select0 = '0; id_opb_select1 = '0;
    cdb_complete0 = 1'b0; cdb_complete1 = 1'b0;
    cdb_prf_dest_pr_idx0 = '0; cdb_prf_dest_pr_idx1 = '0;
    rs_alu_avail = 2'b00;
`ifdef RS_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_slot0(input int pa, input int pb, input bit ra, input bit rb);
    id_valid_inst0 = 1'b1;
    id_pra_idx0 = 7'(pa); id_prb_idx0 = 7'(pb);
    id_pra_ready0 = ra;   id_prb_ready0 = rb;
    id_NPC0 = 64'h1000 + 64'(pa); id_IR0 = 32'(pb); id_dest_pr_idx0 = 7'(pa);
  endtask

  task automatic set_slot1(input int pa, input int pb, input bit ra, input bit rb);
    id_valid_inst1 = 1'b1;
    id_pra_idx1 = 7'(pa); id_prb_idx1 = 7'(pb);
    id_pra_ready1 = ra;   id_prb_ready1 = rb;
    id_NPC1 = 64'h2000 + 64'(pa); id_IR1 = 32'(pb); id_dest_pr_idx1 = 7'(pa);
  endtask

  initial begin
    vecs[0]  = '{1,0, 15,20,1,1,  0, 0,0,0,  0, 0,0, 0, 3, 1,0,15, 0};
    vecs[1]  = '{1,1,  3,30,1,1,  4,31,1,1,  0, 0,0, 0, 3, 1,1, 3, 4};
    vecs[2]  = '{1,1,  3,30,1,1,  4,31,1,1,  0, 0,0, 0, 1, 1,0, 3, 0};
    vecs[3]  = '{1,1,  3,30,1,1,  4,31,1,1,  0, 0,0, 0, 2, 0,1, 0, 3};
    vecs[4]  = '{1,1,  3,30,1,1,  4,31,1,1,  0, 0,0, 0, 0, 0,0, 0, 0};
    vecs[5]  = '{1,0,  5, 9,1,0,  0, 0,0,0,  1, 9,0, 0, 3, 1,0, 5, 0};
    vecs[6]  = '{1,0,  5, 9,1,0,  0, 0,0,0,  0, 0,0, 0, 3, 0,0, 0, 0};
    vecs[7]  = '{1,1, 10,11,1,0, 12,13,1,1,  0, 0,0, 0, 3, 1,0,12, 0};
    vecs[8]  = '{0,1,  0, 0,0,0, 22,23,1,1,  0, 0,0, 0, 3, 1,0,22, 0};
    vecs[9]  = '{1,0, 33,34,0,1,  0, 0,0,0,  0, 0,1,33, 3, 1,0,33, 0};
    vecs[10] = '{1,0, 50,51,0,1,  0, 0,0,0,  1,49,1,52, 3, 0,0, 0, 0};
    vecs[11] = '{1,0, 60,60,0,0,  0, 0,0,0,  1,60,1,60, 3, 1,0,60, 0};
    vecs[12] = '{1,1, 10,11,1,0, 12,13,1,1,  0, 0,0, 0, 2, 0,1, 0,12};

    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("reset_valid0", 64'(rs_valid_inst0), 64'd0);
    chk("reset_valid1", 64'(rs_valid_inst1), 64'd0);
    chk("reset_npc0", rs_NPC0, 64'd0);
    chk("reset_pra1", 64'(rs_pra_idx1), 64'd0);
    chk("reset_cnt", 64'(rs_avail_cnt), 64'd2);

    // Table-driven single dispatch/issue scenarios.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      if (vecs[i].v0 != 0) set_slot0(vecs[i].pa0, vecs[i].pb0, vecs[i].ra0 != 0, vecs[i].rb0 != 0);
      if (vecs[i].v1 != 0) set_slot1(vecs[i].pa1, vecs[i].pb1, vecs[i].ra1 != 0, vecs[i].rb1 != 0);
      cdb_complete0 = (vecs[i].c0 != 0); cdb_prf_dest_pr_idx0 = 7'(vecs[i].t0);
      cdb_complete1 = (vecs[i].c1 != 0); cdb_prf_dest_pr_idx1 = 7'(vecs[i].t1);
      rs_alu_avail = 2'(vecs[i].avail);
      tick();
      chk($sformatf("vec%0d_dispatch_edge_valid0", i), 64'(rs_valid_inst0), 64'd0);
      clear_inputs();
      rs_alu_avail = 2'(vecs[i].avail);
      tick();
      chk($sformatf("vec%0d_valid0", i), 64'(rs_valid_inst0), 64'(vecs[i].ev0));
      chk($sformatf("vec%0d_valid1", i), 64'(rs_valid_inst1), 64'(vecs[i].ev1));
      if (vecs[i].ev0 != 0) chk($sformatf("vec%0d_pra0", i), 64'(rs_pra_idx0), 64'(vecs[i].ep0));
      if (vecs[i].ev1 != 0) chk($sformatf("vec%0d_pra1", i), 64'(rs_pra_idx1), 64'(vecs[i].ep1));
    end

    // Full field pass-through, then hold with no selection.
    do_reset();
    set_slot0(15, 20, 1'b1, 1'b1);
    id_NPC0 = 64'hdead_beef_0000_0004; id_IR0 = 32'h1234_5678;
    id_dest_ar_idx0 = 5'd17; id_dest_pr_idx0 = 7'd99;
    id_opa_select0 = 2'd2; id_opb_select0 = 2'd3;
    rs_alu_avail = 2'b11;
    tick();
    clear_inputs();
    rs_alu_avail = 2'b11;
    tick();
    chk("fld_valid0", 64'(rs_valid_inst0), 64'd1);
    chk("fld_valid1", 64'(rs_valid_inst1), 64'd0);
    chk("fld_npc", rs_NPC0, 64'hdead_beef_0000_0004);
    chk("fld_ir", 64'(rs_IR0), 64'h1234_5678);
    chk("fld_dest_ar", 64'(rs_dest_ar_idx0), 64'd17);
    chk("fld_dest_pr", 64'(rs_dest_pr_idx0), 64'd99);
    chk("fld_pra", 64'(rs_pra_idx0), 64'd15);
    chk("fld_prb", 64'(rs_prb_idx0), 64'd20);
    chk("fld_opa", 64'(rs_opa_select0), 64'd2);
    chk("fld_opb", 64'(rs_opb_select0), 64'd3);
    tick();
    chk("hold_valid0", 64'(rs_valid_inst0), 64'd0);
    chk("hold_npc", rs_NPC0, 64'hdead_beef_0000_0004);

    // Late CDB wakeup: issue exactly one cycle after the broadcast edge, never twice.
    do_reset();
    set_slot0(1, 42, 1'b1, 1'b0);
    rs_alu_avail = 2'b11;
    tick();
    clear_inputs();
    rs_alu_avail = 2'b11;
    tick();
    chk("wake_wait1", 64'(rs_valid_inst0), 64'd0);
    tick();
    chk("wake_wait2", 64'(rs_valid_inst0), 64'd0);
    cdb_complete1 = 1'b1; cdb_prf_dest_pr_idx1 = 7'd42;
    tick();
    cdb_complete1 = 1'b0;
    chk("wake_bcast_edge", 64'(rs_valid_inst0), 64'd0);
    tick();
    chk("wake_issue", 64'(rs_valid_inst0), 64'd1);
    chk("wake_prb", 64'(rs_prb_idx0), 64'd42);
    tick();
    chk("wake_no_reissue", 64'(rs_valid_inst0), 64'd0);

    // Fill all eight entries unready, then drain through slot 1 only.
    do_reset();
    rs_alu_avail = 2'b10;
    for (int k = 0; k < 3; k++) begin
      set_slot0(40 + 2 * k, 100, 1'b0, 1'b1);
      set_slot1(41 + 2 * k, 100, 1'b0, 1'b1);
      tick();
    end
    clear_inputs();
    rs_alu_avail = 2'b10;
    chk("fill6_cnt", 64'(rs_avail_cnt), 64'd2);
    set_slot0(46, 100, 1'b0, 1'b1);
    tick();
    clear_inputs();
    rs_alu_avail = 2'b10;
    chk("fill7_cnt", 64'(rs_avail_cnt), 64'd1);
    set_slot0(47, 100, 1'b0, 1'b1);
    tick();
    clear_inputs();
    rs_alu_avail = 2'b10;
    chk("full_cnt", 64'(rs_avail_cnt), 64'd0);
    chk("full_no_issue", 64'(rs_valid_inst1), 64'd0);
    for (int c = 0; c < 9; c++) begin
      cdb_complete0 = (c < 4); cdb_prf_dest_pr_idx0 = 7'(40 + 2 * c);
      cdb_complete1 = (c < 4); cdb_prf_dest_pr_idx1 = 7'(41 + 2 * c);
      tick();
      if (c >= 1) begin
        chk($sformatf("drain%0d_valid1", c - 1), 64'(rs_valid_inst1), 64'd1);
        chk($sformatf("drain%0d_pra1", c - 1), 64'(rs_pra_idx1), 64'(40 + c - 1));
        chk($sformatf("drain%0d_valid0", c - 1), 64'(rs_valid_inst0), 64'd0);
      end
    end
    clear_inputs();
    rs_alu_avail = 2'b10;
    tick();
    chk("drain_done_valid1", 64'(rs_valid_inst1), 64'd0);
    chk("drain_done_cnt", 64'(rs_avail_cnt), 64'd2);

    // Asynchronous reset in the middle of an issue stream.
    do_reset();
    rs_alu_avail = 2'b10;
    set_slot0(70, 100, 1'b0, 1'b1); set_slot1(71, 100, 1'b0, 1'b1);
    tick();
    set_slot0(72, 100, 1'b0, 1'b1); set_slot1(73, 100, 1'b0, 1'b1);
    tick();
    clear_inputs();
    set_slot0(74, 100, 1'b0, 1'b1);
    rs_alu_avail = 2'b10;
    tick();
    clear_inputs();
    rs_alu_avail = 2'b10;
    cdb_complete0 = 1'b1; cdb_prf_dest_pr_idx0 = 7'd70;
    cdb_complete1 = 1'b1; cdb_prf_dest_pr_idx1 = 7'd71;
    tick();
    cdb_prf_dest_pr_idx0 = 7'd72; cdb_prf_dest_pr_idx1 = 7'd73;
    tick();
    chk("midrst_pre_valid1", 64'(rs_valid_inst1), 64'd1);
    chk("midrst_pre_pra1", 64'(rs_pra_idx1), 64'd70);
    cdb_complete0 = 1'b0; cdb_complete1 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid0", 64'(rs_valid_inst0), 64'd0);
    chk("midrst_valid1", 64'(rs_valid_inst1), 64'd0);
    chk("midrst_pra1", 64'(rs_pra_idx1), 64'd0);
    chk("midrst_cnt", 64'(rs_avail_cnt), 64'd2);
    tick();
    reset = 1'b0;
    rs_alu_avail = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("postrst%0d_valid0", c), 64'(rs_valid_inst0), 64'd0);
      chk($sformatf("postrst%0d_valid1", c), 64'(rs_valid_inst1), 64'd0);
    end

`ifdef RS_FLUSH_EN
    // Flush drops four parked ready entries plus a same-edge dispatch.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_slot0(80 + 2 * k, 100, 1'b1, 1'b1);
      set_slot1(81 + 2 * k, 100, 1'b1, 1'b1);
      tick();
    end
    clear_inputs();
    set_slot0(90, 100, 1'b1, 1'b1);
    rs_alu_avail = 2'b11;
    flush = 1'b1;
    tick();
    clear_inputs();
    rs_alu_avail = 2'b11;
    chk("flush_valid0", 64'(rs_valid_inst0), 64'd0);
    chk("flush_valid1", 64'(rs_valid_inst1), 64'd0);
    chk("flush_cnt", 64'(rs_avail_cnt), 64'd2);
    tick();
    chk("flush_after_valid0", 64'(rs_valid_inst0), 64'd0);
    chk("flush_after_valid1", 64'(rs_valid_inst1), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_alu_issue.md
Name: rs_alu_issue

Overview:
- 8-entry reservation station that drives the issue side of the alu_mul interface.
- Accepts up to 2 dispatched instructions per cycle and wakes source operands from CDB tags.
- Selects up to 2 ready entries per cycle, gated by rs_alu_avail, and issues them as registered rs_* signals.
- Also emits PRF read indices so prf_pra*/prf_prb* arrive alongside the issued instruction.

Parameters:
- RS_SIZE, 8, number of entries (power of 2, ≥2)
- PR_W, 7, physical register tag width
- AR_W, 5, architectural register index width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all entries and outputs
- id_valid_inst0/1  in  1  dispatch slot valid
- id_NPC0/1  in  64  instruction PC+4
- id_IR0/1  in  32  instruction word
- id_dest_ar_idx0/1  in  AR_W  destination architectural register
- id_dest_pr_idx0/1  in  PR_W  destination physical register
- id_pra_idx0/1, id_prb_idx0/1  in  PR_W  source A/B physical tags
- id_pra_ready0/1, id_prb_ready0/1  in  1  source already available at dispatch
- id_opa_select0/1, id_opb_select0/1  in  2  operand mux selects, passed through
- cdb_complete0/1  in  1  CDB broadcast valid
- cdb_prf_dest_pr_idx0/1  in  PR_W  CDB broadcast tag
- rs_alu_avail  in  2  per-slot execution unit can accept this cycle
- rs_avail_cnt  out  2  dispatch credits = min(free entries, 2)
- rs_valid_inst0/1  out  1  issued instruction valid
- rs_NPC0/1, rs_IR0/1, rs_dest_ar_idx0/1, rs_dest_pr_idx0/1, rs_opa_select0/1, rs_opb_select0/1  out  widths as the id_* equivalents  issued fields
- rs_pra_idx0/1, rs_prb_idx0/1  out  PR_W  PRF read addresses for the issued instruction

Behaviour:
- Entry state: valid, fields, pra_rdy, prb_rdy. An entry is ready when valid & pra_rdy & prb_rdy.
- Reset:
  - all entries invalid; every rs_* output 0
  - rs_avail_cnt reflects an empty station (2) once reset is low.
- Dispatch:
  - id slot 0 allocates the lowest-index free entry; slot 1 the next-lowest free entry.
  - Free means invalid at the start of the cycle. Entries freed by same-cycle issue are not reused until the next cycle.
- rs_avail_cnt:
  - combinational from registered occupancy only.
  - Upstream must not assert more dispatch valids than rs_avail_cnt. Excess dispatches are dropped; a simulation assertion flags them.
- Wakeup:
  - On each edge, any valid entry source whose tag equals a valid CDB tag sets its rdy bit.
  - Same-cycle dispatch bypass: a dispatched source matching a valid CDB tag in that cycle is stored ready.
  - Tag matches on both CDB ports are harmless.
- Select (combinational), on entries ready at the start of the cycle:
  - Candidates are taken in ascending index order: first-ready, then second-ready.
  - rs_alu_avail=11: first→slot0, second→slot1.
  - 01: first→slot0.
  - 10: first→slot1.
  - 00: no issue.
- An entry woken in cycle t is first selectable in cycle t+1.
- Issue:
  - Selected fields are registered into the rs_* outputs at the edge; selected entries are invalidated at the same edge.
  - A slot with no selection drives rs_valid_instK=0 and holds its other rs_* fields at their previous values.
- Latency: dispatch (edge t) → earliest rs_valid_inst at edge t+1, when dispatched with both sources ready.
- Full: 8 valid entries → rs_avail_cnt=0. With 7 valid → rs_avail_cnt=1.
- An entry never issues twice. No entry is allocated while valid.

Optional Feature:
- RS_FLUSH_EN:
  - Adds input `flush` (1 bit).
  - flush=1 at an edge invalidates all entries, suppresses that edge's dispatch, and forces rs_valid_inst0/1=0 on the next cycle.
  - flush takes priority over dispatch, wakeup and issue.
- Without the macro: no port, no flush logic.

Decomposition:
- Shared defines header (sys_defs.vh): ALU_OPA_*/ALU_OPB_* select encodings, PR_W/AR_W widths, entry-field bit ranges.
- One sub-module, rs_psel:
  - parameterised RS_SIZE-bit two-grant priority selector.
  - Outputs two one-hot grants: lowest and second-lowest set bit.
  - Instantiated twice: once for free-entry allocation, once for ready-entry selection.

Test Plan:
1. Reset high mid-operation with 5 valid entries → all rs_valid_inst=0 immediately (async); after release rs_avail_cnt=2 and no issue occurs.
2. Dispatch slot0 with pra=15/prb=20 tags ready, rs_alu_avail=11 → next edge rs_valid_inst0=1, rs_pra_idx0=15, rs_prb_idx0=20, fields match; rs_valid_inst1=0.
3. Dispatch entry with prb tag 42 not ready; two cycles later cdb_complete1=1, tag 42 → issued exactly one cycle after the broadcast edge.
4. Dispatch with source tag 9 while CDB broadcasts 9 in the same cycle → issues next edge (bypass).
5. Fill 8 entries with unready sources → rs_avail_cnt=0. Wake all with rs_alu_avail=10 → one issue per cycle, only on slot1, in index order 0..7.
6. (RS_FLUSH_EN) 4 valid entries plus a dispatch, flush=1 → next cycle no issue, rs_avail_cnt=2, dispatched instruction absent.
